// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-unit definitions: bus width, NOP encoding and fetch-buffer entry states.
package ifu_fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        ENT_EMPTY = 2'b00,
        ENT_WAIT  = 2'b01,
        ENT_FULL  = 2'b10
    } entry_state_e;

    function automatic logic [XLEN-1:0] inst_or_nop(
        input logic            valid,
        input logic [XLEN-1:0] inst,
        input logic [XLEN-1:0] nop
    );
        return valid ? inst : nop;
    endfunction

endpackage

// File: rtl/ifu_fetch_entry.sv
// One fetch-buffer slot: lifecycle state plus the captured PC and instruction word.
//   state     | meaning
//   ENT_EMPTY | free, may be allocated by a granted request
//   ENT_WAIT  | request granted, instruction data still outstanding
//   ENT_FULL  | instruction captured, waiting for decode to consume it
module fetch_entry
    import ifu_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic            i_alloc,
    input  logic [XLEN-1:0] i_alloc_pc,
    input  logic            i_fill,
    input  logic [XLEN-1:0] i_fill_inst,
    input  logic            i_consume,
    output entry_state_e    o_state,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_inst
);

    entry_state_e    r_state;
    entry_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;
    logic            w_do_alloc;
    logic            w_do_fill;

    assign w_do_alloc = ~i_flush & i_alloc & (r_state == ENT_EMPTY);
    assign w_do_fill  = ~i_flush & i_fill  & (r_state == ENT_WAIT);

    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = ENT_EMPTY;
        end else begin
            case (r_state)
                ENT_EMPTY: if (i_alloc)   w_state_nxt = ENT_WAIT;
                ENT_WAIT:  if (i_fill)    w_state_nxt = ENT_FULL;
                ENT_FULL:  if (i_consume) w_state_nxt = ENT_EMPTY;
                default:                  w_state_nxt = ENT_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ENT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A flush only frees the slot; stale pc/inst are harmless because state gates their use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc   <= '0;
            r_inst <= '0;
        end else begin
            if (w_do_alloc) r_pc   <= i_alloc_pc;
            if (w_do_fill)  r_inst <= i_fill_inst;
        end
    end

    assign o_state = r_state;
    assign o_pc    = r_pc;
    assign o_inst  = r_inst;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch buffer: issues in-order memory requests, captures responses into a
// circular buffer and presents the oldest instruction to decode; branches flush it.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int               DEPTH    = 2,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            ce_i,
    input  logic            branch_flag_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            pc_stall_o,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_inst_o,
    input  logic            id_ready_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_fill_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_discard;

    entry_state_e     w_state [DEPTH];
    logic [XLEN-1:0]  w_pc    [DEPTH];
    logic [XLEN-1:0]  w_inst  [DEPTH];

    logic [CNT_W-1:0] w_wait_cnt;
    logic [CNT_W-1:0] w_outstanding;
    logic             w_req;
    logic             w_grant;
    logic             w_fill;
    logic             w_consume;
    logic             w_head_valid;
    logic             w_fill_wait;

    always_comb begin
        w_wait_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_state[i] == ENT_WAIT) w_wait_cnt = w_wait_cnt + CNT_W'(1);
        end
    end

    // No request can issue while discarding, so at most one of the two terms is non-zero.
    assign w_outstanding = w_wait_cnt + r_discard;

    assign w_head_valid = (w_state[r_rd_ptr] == ENT_FULL);
    assign w_fill_wait  = (w_state[r_fill_ptr] == ENT_WAIT);

    assign w_req     = rst & ce_i & ~branch_flag_i
                     & (w_state[r_wr_ptr] == ENT_EMPTY) & (r_discard == '0);
    assign w_grant   = w_req & imem_gnt_i;
    assign w_fill    = imem_rvalid_i & (r_discard == '0) & w_fill_wait & ~branch_flag_i;
    assign w_consume = w_head_valid & id_ready_i & ~branch_flag_i;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        fetch_entry u_entry (
            .clk         (clk),
            .rst         (rst),
            .i_flush     (branch_flag_i),
            .i_alloc     (w_grant & (r_wr_ptr == PTR_W'(g))),
            .i_alloc_pc  (pc_i),
            .i_fill      (w_fill & (r_fill_ptr == PTR_W'(g))),
            .i_fill_inst (imem_rdata_i),
            .i_consume   (w_consume & (r_rd_ptr == PTR_W'(g))),
            .o_state     (w_state[g]),
            .o_pc        (w_pc[g]),
            .o_inst      (w_inst[g])
        );
    end

    // A branch remembers every in-flight response (including ones already being
    // discarded) so that none of them is ever written into the flushed buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rd_ptr   <= '0;
            r_discard  <= '0;
        end else if (branch_flag_i) begin
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rd_ptr   <= '0;
            if (imem_rvalid_i && (w_outstanding != '0)) begin
                r_discard <= w_outstanding - CNT_W'(1);
            end else begin
                r_discard <= w_outstanding;
            end
        end else begin
            if (w_grant)   r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
            if (w_fill)    r_fill_ptr <= r_fill_ptr + PTR_W'(1);
            if (w_consume) r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
            if (imem_rvalid_i && (r_discard != '0)) r_discard <= r_discard - CNT_W'(1);
        end
    end

    assign imem_req_o  = w_req;
    assign imem_addr_o = pc_i;
    assign pc_stall_o  = ~rst | (~w_grant & ~branch_flag_i);
    assign if_valid_o  = w_head_valid;
    assign if_pc_o     = w_pc[r_rd_ptr];
    assign if_inst_o   = inst_or_nop(w_head_valid, w_inst[r_rd_ptr], NOP_INST);

`ifndef SYNTHESIS
    // A response with nothing in flight is a memory-side protocol error; it is ignored above.
    a_no_orphan_rvalid: assert property (
        @(posedge clk) disable iff (!rst) imem_rvalid_i |-> (w_outstanding != '0)
    );
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: queue-based reference model, in-order memory model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ifu_fetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] STALE = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_i = '0;
    logic        ce_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        pc_stall_o;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        id_ready_i = 1'b0;

    ifu_fetch #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .ce_i          (ce_i),
        .branch_flag_i (branch_flag_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_stall_o    (pc_stall_o),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o),
        .id_ready_i    (id_ready_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // stimulus knobs for the next cycle
    logic        k_rst = 1'b0;
    logic        k_ce = 1'b0;
    logic        k_gnt = 1'b0;
    logic        k_ready = 1'b0;
    logic        k_branch = 1'b0;
    logic [31:0] k_target = '0;
    int          k_lat_min = 0;
    int          k_lat_max = 0;

    // reference model: buffer contents in program order, stale-response count, PC stage
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];
    bit          q_full[$];
    int          m_disc = 0;
    logic [31:0] m_pc = '0;

    // memory model: in-order pending responses
    logic [31:0] p_data[$];
    int          p_ready[$];

    // DUT values sampled mid-cycle
    logic        s_req, s_stall, s_valid, s_rvalid;
    logic [31:0] s_addr, s_pc, s_inst;
    int          s_disc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic        exp_req, exp_stall, exp_valid;
        logic [31:0] exp_inst;
        int          pending;
        @(posedge clk);
        #1;
        cyc++;
        if (!k_rst) begin
            q_pc.delete(); q_inst.delete(); q_full.delete();
            p_data.delete(); p_ready.delete();
            m_disc = 0;
            m_pc   = '0;
        end
        rst           = k_rst;
        ce_i          = k_ce;
        imem_gnt_i    = k_gnt;
        id_ready_i    = k_ready;
        branch_flag_i = k_branch;
        pc_i          = m_pc;
        imem_rvalid_i = k_rst && (p_ready.size() > 0) && (p_ready[0] <= cyc);
        imem_rdata_i  = imem_rvalid_i ? p_data[0] : $urandom;

        @(negedge clk);
        s_req    = imem_req_o;
        s_addr   = imem_addr_o;
        s_stall  = pc_stall_o;
        s_valid  = if_valid_o;
        s_pc     = if_pc_o;
        s_inst   = if_inst_o;
        s_rvalid = imem_rvalid_i;
        s_disc   = int'(dut.r_discard);

        exp_req   = k_rst && k_ce && !k_branch && (q_pc.size() < DEPTH) && (m_disc == 0);
        exp_stall = !k_rst || (!(exp_req && k_gnt) && !k_branch);
        exp_valid = k_rst && (q_full.size() > 0) && q_full[0];
        exp_inst  = exp_valid ? q_inst[0] : NOP;

        chk_b("req", s_req, exp_req);
        chk("addr", s_addr, m_pc);
        chk_b("stall", s_stall, exp_stall);
        chk_b("valid", s_valid, exp_valid);
        chk("inst", s_inst, exp_inst);
        if (exp_valid) chk("pc", s_pc, q_pc[0]);

        if (k_rst) begin
            if (imem_rvalid_i) begin
                void'(p_data.pop_front());
                void'(p_ready.pop_front());
            end
            if (k_branch) begin
                pending = m_disc;
                foreach (q_full[i]) if (!q_full[i]) pending++;
                if (imem_rvalid_i && pending > 0) pending--;
                m_disc = pending;
                q_pc.delete(); q_inst.delete(); q_full.delete();
                foreach (p_data[i]) p_data[i] = STALE;
                m_pc = k_target;
            end else begin
                if (imem_rvalid_i) begin
                    if (m_disc > 0) begin
                        m_disc--;
                    end else begin
                        for (int i = 0; i < q_full.size(); i++) begin
                            if (!q_full[i]) begin
                                q_full[i] = 1'b1;
                                q_inst[i] = imem_rdata_i;
                                break;
                            end
                        end
                    end
                end
                if (exp_valid && k_ready) begin
                    void'(q_pc.pop_front());
                    void'(q_inst.pop_front());
                    void'(q_full.pop_front());
                end
                if (exp_req && k_gnt) begin
                    q_pc.push_back(m_pc);
                    q_inst.push_back('0);
                    q_full.push_back(1'b0);
                    p_data.push_back(mem_word(m_pc));
                    p_ready.push_back(cyc + 1 + int'($urandom_range(k_lat_max, k_lat_min)));
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic set_idle();
        k_ce = 1'b0; k_gnt = 1'b0; k_ready = 1'b0; k_branch = 1'b0;
        k_target = '0; k_lat_min = 0; k_lat_max = 0;
    endtask

    task automatic do_reset();
        set_idle();
        k_rst = 1'b0;
        k_ce  = 1'b1;
        k_gnt = 1'b1;
        step();
        chk_b("rst_req", s_req, 1'b0);
        chk_b("rst_valid", s_valid, 1'b0);
        chk("rst_inst", s_inst, 32'h0000_0013);
        chk_b("rst_stall", s_stall, 1'b1);
        step();
        set_idle();
        k_rst = 1'b1;
    endtask

    logic [31:0] seen_pc[3];
    logic [31:0] seen_inst[3];
    int          n_seen;
    int          grants;
    int          stale_seen;
    logic [31:0] first_pc, first_inst;

    initial begin
        // zero-wait streaming with decode always ready
        do_reset();
        foreach (seen_pc[i]) begin seen_pc[i] = '1; seen_inst[i] = '1; end
        k_ce = 1'b1; k_gnt = 1'b1; k_ready = 1'b1;
        n_seen = 0;
        for (int i = 0; i < 20 && n_seen < 3; i++) begin
            step();
            if (s_valid) begin
                seen_pc[n_seen]   = s_pc;
                seen_inst[n_seen] = s_inst;
                n_seen++;
            end
        end
        chk("stream_count", 32'(n_seen), 32'd3);
        chk("stream_pc0", seen_pc[0], 32'h0000_0000);
        chk("stream_inst0", seen_inst[0], 32'hC0DE_0000);
        chk("stream_pc1", seen_pc[1], 32'h0000_0004);
        chk("stream_inst1", seen_inst[1], 32'hC0DE_0004);
        chk("stream_pc2", seen_pc[2], 32'h0000_0008);
        chk("stream_inst2", seen_inst[2], 32'hC0DE_0008);

        // decode stalled: buffer fills after exactly DEPTH grants
        do_reset();
        k_ce = 1'b1; k_gnt = 1'b1; k_ready = 1'b0;
        grants = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (s_req && imem_gnt_i) grants++;
        end
        chk("full_grants", 32'(grants), 32'd2);
        chk_b("full_req", s_req, 1'b0);
        chk_b("full_stall", s_stall, 1'b1);
        chk_b("full_valid", s_valid, 1'b1);
        chk("full_head_pc", s_pc, 32'h0000_0000);
        k_ready = 1'b1;
        step();
        chk("release_pc0", s_pc, 32'h0000_0000);
        step();
        chk_b("release_valid1", s_valid, 1'b1);
        chk("release_pc1", s_pc, 32'h0000_0004);

        // branch with two responses still in flight
        do_reset();
        k_ce = 1'b1; k_gnt = 1'b1; k_ready = 1'b0; k_lat_min = 20; k_lat_max = 20;
        step();
        step();
        k_branch = 1'b1; k_target = 32'h0000_0100;
        step();
        k_branch = 1'b0; k_ready = 1'b1; k_lat_min = 0; k_lat_max = 1;
        step();
        chk("flush_disc", 32'(s_disc), 32'd2);
        chk_b("flush_req_blocked", s_req, 1'b0);
        stale_seen = 0;
        first_pc   = '1;
        first_inst = '1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (s_inst == STALE) stale_seen++;
            if (s_valid) begin
                first_pc   = s_pc;
                first_inst = s_inst;
                break;
            end
        end
        chk("flush_first_pc", first_pc, 32'h0000_0100);
        chk("flush_first_inst", first_inst, 32'hC0DE_0100);
        chk("flush_no_stale", 32'(stale_seen), 32'd0);

        // branch coinciding with the only outstanding response
        do_reset();
        k_ce = 1'b1; k_gnt = 1'b1; k_ready = 1'b0;
        step();
        k_branch = 1'b1; k_gnt = 1'b0; k_target = 32'h0000_0200;
        step();
        chk_b("br_rv_rvalid", s_rvalid, 1'b1);
        k_branch = 1'b0; k_gnt = 1'b1;
        step();
        chk("br_rv_disc", 32'(s_disc), 32'd0);
        chk_b("br_rv_req", s_req, 1'b1);
        chk("br_rv_addr", s_addr, 32'h0000_0200);

        // grant withheld: request held, PC frozen, nothing allocated
        do_reset();
        k_ce = 1'b1; k_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nognt_addr", s_addr, 32'h0000_0000);
            chk_b("nognt_stall", s_stall, 1'b1);
            chk_b("nognt_req", s_req, 1'b1);
        end

        // reset in the middle of outstanding traffic
        do_reset();
        k_ce = 1'b1; k_gnt = 1'b1; k_lat_min = 3; k_lat_max = 5;
        for (int i = 0; i < 3; i++) step();
        k_rst = 1'b0;
        step();
        chk_b("midrst_req", s_req, 1'b0);
        chk_b("midrst_valid", s_valid, 1'b0);
        chk("midrst_inst", s_inst, 32'h0000_0013);
        chk_b("midrst_stall", s_stall, 1'b1);
        k_rst = 1'b1;
        set_idle();
        k_ce = 1'b1; k_gnt = 1'b1;
        step();
        chk_b("midrst_first_req", s_req, 1'b1);
        chk("midrst_first_addr", s_addr, 32'h0000_0000);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            k_ce      = ($urandom_range(7, 0) != 0);
            k_gnt     = ($urandom_range(3, 0) != 0);
            k_ready   = ($urandom_range(2, 0) != 0);
            k_branch  = ($urandom_range(24, 0) == 0);
            k_target  = $urandom & 32'hFFFF_FFFC;
            k_lat_min = 0;
            k_lat_max = int'($urandom_range(3, 0));
            k_rst     = ($urandom_range(599, 0) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
